// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: RX writer state encoding, status word layout, sizing defaults.
// Also used by the TX formatter for the core-nibble position in DMAC byte 5.
package eth_pkg;

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_COLLECT = 3'd1,
      RX_WAITEND = 3'd2,
      RX_FLUSH   = 3'd3,
      RX_STATUS  = 3'd4,
      RX_DROP    = 3'd5
   } rx_state_t;

   localparam int MAX_BYTES_DEF      = 1518;
   localparam int MIN_FREE_WORDS_DEF = 380;
   localparam int DMAC_BYTES         = 6;

   // Destination core lives in the low nibble of DMAC byte 5.
   localparam int CORE_NIBBLE_LSB = 0;

   localparam int ST_CNT_LSB   = 0;
   localparam int ST_CNT_W     = 11;
   localparam int ST_CORE_LSB  = 11;
   localparam int ST_CORE_W    = 4;
   localparam int ST_MATCH_BIT = 15;
   localparam int ST_BCAST_BIT = 16;
   localparam int ST_GOOD_BIT  = 17;
   localparam int ST_TRUNC_BIT = 18;

   function automatic logic [31:0] pack_status(input logic [10:0] cnt,
                                               input logic [3:0]  core,
                                               input logic        match,
                                               input logic        bcast,
                                               input logic        good,
                                               input logic        trunc);
      logic [31:0] s;
      s                            = '0;
      s[ST_CNT_LSB +: ST_CNT_W]    = cnt;
      s[ST_CORE_LSB +: ST_CORE_W]  = core;
      s[ST_MATCH_BIT]              = match;
      s[ST_BCAST_BIT]              = bcast;
      s[ST_GOOD_BIT]               = good;
      s[ST_TRUNC_BIT]              = trunc;
      return s;
   endfunction

endpackage

// File: rtl/eth_rx_addr_filter.sv
// Byte-serial destination MAC comparator: own-address match, broadcast, destination core.
// Results settle one cycle after DMAC byte 5; they read as zero until all six bytes are seen.
module eth_rx_addr_filter
   import eth_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic        byteVld_i,
   input  logic [10:0] byteIdx_i,
   input  logic [7:0]  byte_i,
   input  logic [43:0] smac_i,
   output logic        match_o,
   output logic        bcast_o,
   output logic [3:0]  destCore_o
);

   logic        match_q, match_d;
   logic        bcast_q, bcast_d;
   logic        done_q,  done_d;
   logic [3:0]  core_q,  core_d;
   logic [10:0] idx;
   logic [7:0]  expByte;
   logic        eq;

   always_comb begin
      // The first byte arrives in the same cycle as start, before byteIdx_i is rewound.
      idx = start_i ? 11'd0 : byteIdx_i;
      case (idx[2:0])
         3'd0:    expByte = smac_i[43:36];
         3'd1:    expByte = smac_i[35:28];
         3'd2:    expByte = smac_i[27:20];
         3'd3:    expByte = smac_i[19:12];
         3'd4:    expByte = smac_i[11:4];
         default: expByte = {smac_i[3:0], 4'h0};
      endcase
      eq = (idx[2:0] == 3'd5) ? (byte_i[7:4] == smac_i[3:0]) : (byte_i == expByte);

      match_d = match_q;
      bcast_d = bcast_q;
      done_d  = done_q;
      core_d  = core_q;
      if (start_i) begin
         match_d = 1'b1;
         bcast_d = 1'b1;
         done_d  = 1'b0;
         core_d  = 4'h0;
      end
      if (byteVld_i && idx < 11'(DMAC_BYTES)) begin
         match_d = match_d & eq;
         bcast_d = bcast_d & (byte_i == 8'hFF);
         if (idx == 11'(DMAC_BYTES - 1)) begin
            done_d = 1'b1;
            core_d = byte_i[CORE_NIBBLE_LSB +: 4];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         match_q <= 1'b0;
         bcast_q <= 1'b0;
         done_q  <= 1'b0;
         core_q  <= 4'h0;
      end else begin
         match_q <= match_d;
         bcast_q <= bcast_d;
         done_q  <= done_d;
         core_q  <= core_d;
      end
   end

   assign match_o    = match_q & done_q;
   assign bcast_o    = bcast_q & done_q;
   assign destCore_o = done_q ? core_q : 4'h0;

endmodule

// File: rtl/eth_rx_writer.sv
// Packs MAC RX bytes into 32-bit DMA words (1-cycle latency) and writes one status word per frame.
// No backpressure: frames are admitted only with a full frame of fifo space, otherwise dropped and counted.
module eth_rx_writer
   import eth_pkg::*;
#(
   parameter int MAX_BYTES      = MAX_BYTES_DEF,
   parameter int MIN_FREE_WORDS = MIN_FREE_WORDS_DEF
)(
   input  logic        ethTXclock,
   input  logic        reset,
   input  logic [7:0]  RXdata,
   input  logic        RXdataValid,
   input  logic        RXgoodFrame,
   input  logic        RXbadFrame,
   input  logic [43:0] SMACaddr,
   input  logic [9:0]  dataFifoFree,
   input  logic        statusFifoFull,
   output logic [31:0] wordOut,
   output logic        wordWrite,
   output logic [31:0] statusOut,
   output logic        statusWrite,
   output logic [15:0] dropCount
);

   localparam logic [10:0] MAX_L      = 11'(MAX_BYTES);
   localparam logic [10:0] MIN_FREE_L = 11'(MIN_FREE_WORDS);

   rx_state_t   state_q, state_d;
   logic        rxValid_q;
   logic [1:0]  byteSel_q, byteSel_d;
   logic [10:0] byteCnt_q, byteCnt_d;
   logic [31:0] acc_q, acc_d;
   logic        trunc_q, trunc_d;
   logic        good_q, good_d;
   logic [31:0] wordOut_q, wordOut_d;
   logic        wordWrite_q, wordWrite_d;
   logic [31:0] statusOut_q, statusOut_d;
   logic        statusWrite_q, statusWrite_d;
   logic [15:0] dropCount_q, dropCount_d;

   logic        frameStart, haveSpace, frameEnd;
   logic        start, accept, store;
   logic [1:0]  selBase;
   logic [10:0] cntBase;
   logic        match, bcast;
   logic [3:0]  destCore;

   eth_rx_addr_filter u_addr_filter (
      .clk_i      (ethTXclock),
      .reset_i    (reset),
      .start_i    (start),
      .byteVld_i  (store),
      .byteIdx_i  (byteCnt_q),
      .byte_i     (RXdata),
      .smac_i     (SMACaddr),
      .match_o    (match),
      .bcast_o    (bcast),
      .destCore_o (destCore)
   );

   always_comb begin
      state_d       = state_q;
      byteSel_d     = byteSel_q;
      byteCnt_d     = byteCnt_q;
      acc_d         = acc_q;
      trunc_d       = trunc_q;
      good_d        = good_q;
      wordOut_d     = wordOut_q;
      wordWrite_d   = 1'b0;
      statusOut_d   = statusOut_q;
      statusWrite_d = 1'b0;
      dropCount_d   = dropCount_q;
      start         = 1'b0;
      accept        = 1'b0;
      store         = 1'b0;

      frameStart = RXdataValid & ~rxValid_q;
      haveSpace  = ({1'b0, dataFifoFree} >= MIN_FREE_L) & ~statusFifoFull;
      frameEnd   = RXgoodFrame | RXbadFrame;

      case (state_q)
         RX_IDLE: begin
            if (frameStart) begin
               if (haveSpace) begin
                  state_d = RX_COLLECT;
                  start   = 1'b1;
                  accept  = 1'b1;
                  trunc_d = 1'b0;
                  good_d  = 1'b0;
               end else begin
                  state_d = RX_DROP;
               end
            end
         end
         RX_COLLECT: begin
            if (RXdataValid) begin
               accept = 1'b1;
            end else if (frameEnd) begin
               good_d  = RXgoodFrame & ~RXbadFrame;
               state_d = RX_FLUSH;
            end else begin
               state_d = RX_WAITEND;
            end
         end
         RX_WAITEND: begin
            if (frameEnd) begin
               good_d  = RXgoodFrame & ~RXbadFrame;
               state_d = RX_FLUSH;
            end
         end
         RX_FLUSH: begin
            // Lanes above byteSel were zeroed when lane 0 was loaded.
            if (byteSel_q != 2'd0) begin
               wordOut_d   = acc_q;
               wordWrite_d = 1'b1;
            end
            state_d = RX_STATUS;
         end
         RX_STATUS: begin
            statusOut_d   = pack_status(byteCnt_q, destCore, match, bcast, good_q, trunc_q);
            statusWrite_d = 1'b1;
            state_d       = RX_IDLE;
         end
         RX_DROP: begin
            if (frameEnd) begin
               if (dropCount_q != 16'hFFFF) dropCount_d = dropCount_q + 16'd1;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      selBase = start ? 2'd0  : byteSel_q;
      cntBase = start ? 11'd0 : byteCnt_q;
      if (accept) begin
         if (cntBase == MAX_L) begin
            trunc_d = 1'b1;
         end else begin
            store = 1'b1;
            if (selBase == 2'd0) acc_d = 32'h0;
            acc_d[{selBase, 3'b000} +: 8] = RXdata;
            if (selBase == 2'd3) begin
               wordOut_d   = acc_d;
               wordWrite_d = 1'b1;
            end
            byteSel_d = selBase + 2'd1;
            byteCnt_d = cntBase + 11'd1;
         end
      end
   end

   always_ff @(posedge ethTXclock) begin
      if (reset) begin
         state_q       <= RX_IDLE;
         // Held high so a frame already running at reset release never looks like a start.
         rxValid_q     <= 1'b1;
         byteSel_q     <= 2'd0;
         byteCnt_q     <= 11'd0;
         acc_q         <= 32'h0;
         trunc_q       <= 1'b0;
         good_q        <= 1'b0;
         wordOut_q     <= 32'h0;
         wordWrite_q   <= 1'b0;
         statusOut_q   <= 32'h0;
         statusWrite_q <= 1'b0;
         dropCount_q   <= 16'h0;
      end else begin
         state_q       <= state_d;
         rxValid_q     <= RXdataValid;
         byteSel_q     <= byteSel_d;
         byteCnt_q     <= byteCnt_d;
         acc_q         <= acc_d;
         trunc_q       <= trunc_d;
         good_q        <= good_d;
         wordOut_q     <= wordOut_d;
         wordWrite_q   <= wordWrite_d;
         statusOut_q   <= statusOut_d;
         statusWrite_q <= statusWrite_d;
         dropCount_q   <= dropCount_d;
      end
   end

   assign wordOut     = wordOut_q;
   assign wordWrite   = wordWrite_q;
   assign statusOut   = statusOut_q;
   assign statusWrite = statusWrite_q;
   assign dropCount   = dropCount_q;

endmodule

// File: tb/tb_eth_rx_writer.sv
// Directed bench for eth_rx_writer: frames are built byte by byte, captured writes checked against hand values.
module tb_eth_rx_writer;

   logic        ethTXclock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  RXdata = 8'h0;
   logic        RXdataValid = 1'b0;
   logic        RXgoodFrame = 1'b0;
   logic        RXbadFrame = 1'b0;
   logic [43:0] SMACaddr = 44'h0012345678A;
   logic [9:0]  dataFifoFree = 10'd512;
   logic        statusFifoFull = 1'b0;
   logic [31:0] wordOut;
   logic        wordWrite;
   logic [31:0] statusOut;
   logic        statusWrite;
   logic [15:0] dropCount;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  fb [0:1599];
   logic [31:0] words_q [$];
   logic [31:0] stat_q [$];
   int          wbase = 0;
   int          sbase = 0;

   eth_rx_writer dut (
      .ethTXclock     (ethTXclock),
      .reset          (reset),
      .RXdata         (RXdata),
      .RXdataValid    (RXdataValid),
      .RXgoodFrame    (RXgoodFrame),
      .RXbadFrame     (RXbadFrame),
      .SMACaddr       (SMACaddr),
      .dataFifoFree   (dataFifoFree),
      .statusFifoFull (statusFifoFull),
      .wordOut        (wordOut),
      .wordWrite      (wordWrite),
      .statusOut      (statusOut),
      .statusWrite    (statusWrite),
      .dropCount      (dropCount)
   );

   always #5 ethTXclock = ~ethTXclock;

   always @(negedge ethTXclock) begin
      if (wordWrite)   words_q.push_back(wordOut);
      if (statusWrite) stat_q.push_back(statusOut);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic build(input int n, input logic [47:0] dmac, input int seed);
      for (int i = 0; i < n; i++)
         fb[i] = (i < 6) ? dmac[47-8*i -: 8] : 8'((i * 13 + seed) & 255);
   endtask

   task automatic drive(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(posedge ethTXclock); #1;
         RXdataValid = 1'b1;
         RXdata      = fb[i];
      end
   endtask

   // mode: 0 good, 1 bad, 2 both pulses; gap 0 puts the pulse on the cycle valid drops
   task automatic finish_frame(input int mode, input int gap);
      @(posedge ethTXclock); #1;
      RXdataValid = 1'b0;
      RXdata      = 8'h0;
      if (gap != 0) begin
         @(posedge ethTXclock); #1;
      end
      RXgoodFrame = (mode == 0 || mode == 2);
      RXbadFrame  = (mode == 1 || mode == 2);
      @(posedge ethTXclock); #1;
      RXgoodFrame = 1'b0;
      RXbadFrame  = 1'b0;
      repeat (8) @(posedge ethTXclock);
      #1;
   endtask

   task automatic mark();
      wbase = words_q.size();
      sbase = stat_q.size();
   endtask

   task automatic check_words(input string tag, input int nst);
      int          nw;
      int          ne;
      logic [31:0] e;
      nw = words_q.size() - wbase;
      ne = (nst + 3) / 4;
      chk({tag, " words"}, nw, ne);
      for (int k = 0; k < nw && k < ne; k++) begin
         for (int j = 0; j < 4; j++)
            e[8*j +: 8] = (4*k + j < nst) ? fb[4*k + j] : 8'h00;
         chk($sformatf("%s w%0d", tag, k), words_q[wbase + k], e);
      end
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      chk({tag, " nstat"}, stat_q.size() - sbase, 1);
      if (stat_q.size() > sbase) chk({tag, " status"}, stat_q[sbase], exp);
   endtask

   initial begin
      // Frame already running while reset is held and released: must be ignored.
      mark();
      build(20, 48'h0, 1);
      drive(0, 5);
      chk("rst wordWrite",   wordWrite,   0);
      chk("rst statusWrite", statusWrite, 0);
      chk("rst wordOut",     wordOut,     0);
      chk("rst statusOut",   statusOut,   0);
      chk("rst dropCount",   dropCount,   0);
      reset = 1'b0;
      drive(5, 20);
      finish_frame(0, 1);
      chk("inprog words",  words_q.size() - wbase, 0);
      chk("inprog status", stat_q.size() - sbase, 0);

      // 64-byte good frame to own address, core 3
      mark();
      build(64, 48'h0012345678A3, 3);
      drive(0, 64);
      finish_frame(0, 1);
      check_words("own64", 64);
      check_status("own64", 32'h00029840);

      // 61-byte good frame, not for us, end pulse on the valid-low cycle
      mark();
      build(61, 48'h0012345679A3, 7);
      drive(0, 61);
      finish_frame(0, 0);
      check_words("odd61", 61);
      check_status("odd61", 32'h0002183D);

      // 64-byte broadcast ending bad
      mark();
      build(64, 48'hFFFFFFFFFFFF, 11);
      drive(0, 64);
      finish_frame(1, 1);
      check_words("bcast", 64);
      check_status("bcast", 32'h00017840);

      // 4-byte frame of FF with both end pulses: no address result, bad
      mark();
      build(4, 48'hFFFFFFFFFFFF, 0);
      drive(0, 4);
      finish_frame(2, 1);
      check_words("short4", 4);
      check_status("short4", 32'h00000004);

      // Reset after byte 20 of a frame
      mark();
      build(60, 48'h0012345678A7, 5);
      drive(0, 20);
      @(posedge ethTXclock); #1;
      reset = 1'b1;
      @(posedge ethTXclock); #1;
      reset = 1'b0;
      chk("midrst pre words", words_q.size() - wbase, 5);
      mark();
      drive(21, 60);
      finish_frame(0, 1);
      chk("midrst post words",  words_q.size() - wbase, 0);
      chk("midrst post status", stat_q.size() - sbase, 0);
      mark();
      build(64, 48'h0012345678A7, 9);
      drive(0, 64);
      finish_frame(0, 1);
      check_words("after rst", 64);
      check_status("after rst", 32'h0002B840);
      chk("after rst dropCount", dropCount, 0);

      // Not enough fifo space at frame start
      mark();
      dataFifoFree = 10'd100;
      build(64, 48'h0012345678A3, 13);
      drive(0, 64);
      dataFifoFree = 10'd512;
      finish_frame(0, 1);
      chk("drop words",     words_q.size() - wbase, 0);
      chk("drop status",    stat_q.size() - sbase, 0);
      chk("drop dropCount", dropCount, 1);
      mark();
      build(64, 48'h0012345678A3, 17);
      drive(0, 64);
      finish_frame(0, 1);
      check_words("postdrop", 64);
      check_status("postdrop", 32'h00029840);
      chk("postdrop dropCount", dropCount, 1);

      // Oversize frame: stored bytes stop at 1518
      mark();
      build(1600, 48'h0012345678A5, 21);
      drive(0, 1600);
      chk("trunc words before flush", words_q.size() - wbase, 379);
      finish_frame(0, 1);
      check_words("trunc", 1518);
      check_status("trunc", 32'h0006ADEE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
